// File: rtl/counter.sv
// Up/down counter with synchronous clear/load, terminal-count flag and wrap pulse.
// Define COUNTER_SATURATE_EN to clamp at the limits instead of wrapping modulo 2^WIDTH.
module counter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] out1,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;

  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   diff_dn;
  logic             crossed;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             sat_hold;
  logic             hold_next;

  // The extra MSB of each extended result is the carry/borrow across the 0 / max boundary.
  always_comb begin
    sum_up  = {1'b0, out1} + STEP_EXT;
    diff_dn = {1'b0, out1} - STEP_EXT;
    crossed = up_dn ? sum_up[WIDTH] : diff_dn[WIDTH];
    stepped = up_dn ? sum_up[WIDTH-1:0] : diff_dn[WIDTH-1:0];
  end

  always_comb begin
    count_next = out1;
    wrap_next  = 1'b0;
    hold_next  = sat_hold;
    if (clr) begin
      count_next = '0;
      hold_next  = 1'b0;
    end else if (load) begin
      count_next = load_val;
      hold_next  = 1'b0;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      // sat_hold suppresses repeat pulses while the counter sits clamped at the same limit.
      if (crossed) begin
        count_next = up_dn ? MAX_VAL : '0;
        wrap_next  = !(sat_hold && (count_next == out1));
        hold_next  = 1'b1;
      end else begin
        count_next = stepped;
        hold_next  = 1'b0;
      end
`else
      count_next = stepped;
      wrap_next  = crossed;
      hold_next  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1     <= '0;
      wrap     <= 1'b0;
      sat_hold <= 1'b0;
    end else begin
      out1     <= count_next;
      wrap     <= wrap_next;
      sat_hold <= hold_next;
    end
  end

  assign tc = up_dn ? (out1 == MAX_VAL) : (out1 == '0);

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter (WIDTH=4, STEP=1); expectations follow
// the COUNTER_SATURATE_EN setting of the build.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       clr;
  logic [3:0] out1;
  logic       tc;
  logic       wrap;

  int checks;
  int errors;

  counter #(.WIDTH(4), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr(clr), .out1(out1), .tc(tc), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, and return 1 ns after it.
  task automatic applyStimulus(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u);
    clr      = c;
    load     = l;
    load_val = lv;
    en       = e;
    up_dn    = u;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [3:0] exp_out, input bit exp_wrap, input bit exp_tc);
    checkOutput({tag, ".out1"}, 32'(out1), 32'(exp_out));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
    checkOutput({tag, ".tc"},   32'(tc),   32'(exp_tc));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 4'h0;
    en       = 1'b1;
    up_dn    = 1'b1;

    // Held in reset with counting enabled: outputs stay 0 across and between edges.
    for (int t = 0; t < 9; t++) begin
      #11;
      checkOutput("rst.out1", 32'(out1), 32'd0);
      checkOutput("rst.wrap", 32'(wrap), 32'd0);
    end
    #1;
    en    = 1'b0;
    rst_n = 1'b1;
    #2;
    checkOutput("release.out1", 32'(out1), 32'd0);

    // Free up-count through the top boundary.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      if (i < 16)
        checkState($sformatf("up%0d", i), 4'(i), 1'b0, (i == 15));
      else
        checkState("up16", SAT ? 4'd15 : 4'd0, 1'b1, SAT);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("after_wrap", SAT ? 4'd15 : 4'd1, 1'b0, SAT);

    // Load beats enable; next enabled edge counts from the loaded value.
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b1, 1'b1);
    checkState("load_a", 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("load_a_inc", 4'hB, 1'b0, 1'b0);

    // Clear beats load and enable.
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
    checkState("load_7", 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
    checkState("clr_load", 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
    checkState("hold", 4'h0, 1'b0, 1'b0);

    // tc follows up_dn combinationally.
    up_dn = 1'b0;
    #1;
    checkOutput("tc_dir", 32'(tc), 32'd1);

    // Down-count below zero, then repeated down edges.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkState("dn1", SAT ? 4'd0 : 4'd15, 1'b1, SAT);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkState("dn2", SAT ? 4'd0 : 4'd14, 1'b0, SAT);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checkState("dn3", SAT ? 4'd0 : 4'd13, 1'b0, SAT);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("dir_up", SAT ? 4'd1 : 4'd14, 1'b0, 1'b0);

    // Boundary event then a load: the load edge must clear the pulse.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
    checkState("load_f", 4'hF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("top_evt", SAT ? 4'd15 : 4'd0, 1'b1, SAT);
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, 1'b1);
    checkState("load_5", 4'h5, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle at out1=9, then resume from 0.
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("pre_rst", 4'h9, 1'b0, 1'b0);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.out1", 32'(out1), 32'd0);
    checkOutput("async_rst.wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkState("resume", 4'h1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter STEP, default 1: increment/decrement amount; legal range 1..2^WIDTH-1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port up_dn, input, 1: direction; 1 = count up, 0 = count down.
REQ-007 Port load, input, 1: synchronous load strobe.
REQ-008 Port load_val, input, WIDTH: value captured when load is high.
REQ-009 Port clr, input, 1: synchronous clear.
REQ-010 Port out1, output, WIDTH: registered counter value.
REQ-011 Port tc, output, 1: terminal-count flag, combinational from out1 and up_dn.
REQ-012 Port wrap, output, 1: registered one-cycle pulse indicating a wrap or saturation event.

Function
REQ-013 Priority per rising edge SHALL be: clr, then load, then en; with none asserted, out1 holds.
REQ-014 clr=1 SHALL set out1 to 0 on the next edge, regardless of load and en.
REQ-015 load=1 with clr=0 SHALL set out1 to load_val on the next edge; en is ignored that cycle.
REQ-016 en=1 with up_dn=1 SHALL set out1 to out1+STEP, modulo 2^WIDTH.
REQ-017 en=1 with up_dn=0 SHALL set out1 to out1-STEP, modulo 2^WIDTH.
REQ-018 Each update SHALL have one-cycle latency: the new value is visible on out1 immediately after the edge.
REQ-019 tc SHALL be 1 when up_dn=1 and out1=2^WIDTH-1, or when up_dn=0 and out1=0; otherwise 0.
REQ-020 wrap SHALL be 1 for exactly the cycle following an en-driven update that crossed the 0 / 2^WIDTH-1 boundary; it is 0 after clr and load updates.
REQ-021 A direction change SHALL take effect on the same edge that up_dn is sampled; there is no pipeline delay.
REQ-022 With WIDTH=4 and STEP=1, free counting SHALL follow 0,1,...,15,0,... (up) and 0,15,14,...,0 (down).

Reset
REQ-023 rst_n=0 SHALL immediately force out1=0 and wrap=0, independent of clk.
REQ-024 Reset assertion mid-count SHALL discard the current value; after deassertion, counting resumes from 0 on the first enabled edge.
REQ-025 Release of rst_n SHALL be treated as synchronous to clk by the integrator; the block adds no synchronizer.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN selects the overflow behaviour.
REQ-027 When COUNTER_SATURATE_EN is defined:
- an up-count that would exceed 2^WIDTH-1 SHALL clamp to 2^WIDTH-1;
- a down-count that would go below 0 SHALL clamp to 0;
- wrap SHALL pulse on the clamping edge;
- a held counter at its limit SHALL NOT re-pulse wrap.
REQ-028 When COUNTER_SATURATE_EN is undefined, the modulo behaviour of REQ-016/REQ-017 SHALL apply.

Verification
REQ-029 rst_n=0 at t=0 with clk toggling every 5 ns, released at 100 ns -> out1=0 and wrap=0 throughout reset, including between clock edges.
REQ-030 WIDTH=4, en=1, up_dn=1, 16 edges from 0 -> out1 steps 1..15 then 0; tc=1 at 15; wrap=1 in the cycle after the 15->0 edge.
REQ-031 load=1, load_val=4'hA, en=1 on the same edge -> out1=4'hA; the next enabled up edge gives 4'hB.
REQ-032 clr=1 and load=1 on the same edge with out1=7 -> out1=0.
REQ-033 up_dn=0, en=1 from out1=0 -> out1=15 and wrap pulse (no macro); with COUNTER_SATURATE_EN defined -> out1 stays 0, a single wrap pulse, then tc remains 1.
REQ-034 rst_n pulsed low mid-cycle at out1=9 -> out1=0 immediately, with no clock edge required.
